// File: rtl/fpu_issue_wb_if.sv
// ============================================================================
// Module      : fpu_issue_wb_if
// Description : Bundle of the request, core, response and fflags signals
//               between the FPU issue/writeback stage and its neighbours.
//               The stage sits on the slave side; the requester, core and
//               consumer together sit on the master side.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fpu_issue_wb_if #(
  parameter int TAG_W = 5
) ();

  // Request channel
  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_func7;
  logic [2:0]       req_func3;
  logic [4:0]       req_rs2;
  logic [63:0]      req_op_a;
  logic [63:0]      req_op_b;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       frm_in;

  // Combinational core interface
  logic [6:0]       fpu_func7;
  logic [2:0]       fpu_func3;
  logic [4:0]       fpu_rs2;
  logic [63:0]      fpu_operand_a;
  logic [63:0]      fpu_operand_b;
  logic [63:0]      fpu_result;
  logic [4:0]       fpu_flags;
  logic             fpu_flag_cmp;

  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_result;
  logic [4:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;

  // Sticky exception flags
  logic             fflags_clr;
  logic [4:0]       fflags_acc;

  modport master (
    output req_valid, req_func7, req_func3, req_rs2, req_op_a, req_op_b,
           req_tag, frm_in,
    input  req_ready,
    input  fpu_func7, fpu_func3, fpu_rs2, fpu_operand_a, fpu_operand_b,
    output fpu_result, fpu_flags, fpu_flag_cmp,
    input  rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_illegal,
    output rsp_ready,
    output fflags_clr,
    input  fflags_acc
  );

  modport slave (
    input  req_valid, req_func7, req_func3, req_rs2, req_op_a, req_op_b,
           req_tag, frm_in,
    output req_ready,
    output fpu_func7, fpu_func3, fpu_rs2, fpu_operand_a, fpu_operand_b,
    input  fpu_result, fpu_flags, fpu_flag_cmp,
    output rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_illegal,
    input  rsp_ready,
    input  fflags_clr,
    output fflags_acc
  );

endinterface

`default_nettype wire

// File: rtl/fpu_issue_wb.sv
// ============================================================================
// Module      : fpu_issue_wb
// Description : Issue/writeback stage around a combinational FPU core.
//               Accepts one request at a time, resolves the dynamic rounding
//               mode, holds the core operands stable for LATENCY cycles,
//               formats the captured result and returns it over a
//               valid/ready response while accumulating sticky fflags.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fpu_issue_wb #(
  parameter int LATENCY = 1,
  parameter int TAG_W   = 5
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  fpu_issue_wb_if.slave   bus
);

  // Counter only has to hold LATENCY-1
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(LATENCY - 1);

  // Opcodes that need special result formatting
  localparam logic [6:0] c_F7_FADD_S   = 7'b0000000;
  localparam logic [6:0] c_F7_FSUB_S   = 7'b0000100;
  localparam logic [6:0] c_F7_FMUL_S   = 7'b0001000;
  localparam logic [6:0] c_F7_FCVT_S_D = 7'b0100000;
  localparam logic [6:0] c_F7_FCVT_S_W = 7'b1101000;
  localparam logic [6:0] c_F7_FCVT_W_S = 7'b1100000;
  localparam logic [6:0] c_F7_FCVT_W_D = 7'b1100001;
  localparam logic [6:0] c_F7_FCMP_S   = 7'b1010000;
  localparam logic [6:0] c_F7_FCMP_D   = 7'b1010001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic [6:0]       func7_q,   func7_d;
  logic [2:0]       func3_q,   func3_d;
  logic [4:0]       rs2_q,     rs2_d;
  logic [63:0]      op_a_q,    op_a_d;
  logic [63:0]      op_b_q,    op_b_d;
  logic [TAG_W-1:0] tag_q,     tag_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [63:0]      result_q,  result_d;
  logic [4:0]       flags_q,   flags_d;
  logic             illegal_q, illegal_d;
  logic [4:0]       acc_q,     acc_d;

  logic             w_req_ready;
  logic             w_accept;
  logic             w_rsp_hs;
  logic             w_is_cmp;
  logic [2:0]       w_rm;
  logic             w_rm_bad;
  logic [63:0]      w_fmt_result;

  assign w_req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready);
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_rsp_hs    = (state_q == ST_RESP) && bus.rsp_ready;

  // Compares carry a predicate in func3, so they skip rounding-mode resolution
  assign w_is_cmp = (bus.req_func7 == c_F7_FCMP_S) || (bus.req_func7 == c_F7_FCMP_D);
  assign w_rm     = (bus.req_func3 == 3'b111) ? bus.frm_in : bus.req_func3;
  assign w_rm_bad = !w_is_cmp &&
                    ((w_rm == 3'b101) || (w_rm == 3'b110) || (w_rm == 3'b111));

  // Shape the raw core result according to the opcode held in the core registers
  always_comb begin
    w_fmt_result = bus.fpu_result;
    case (func7_q)
      c_F7_FCMP_S, c_F7_FCMP_D:
        w_fmt_result = {63'b0, bus.fpu_flag_cmp};
      c_F7_FADD_S, c_F7_FSUB_S, c_F7_FMUL_S, c_F7_FCVT_S_D, c_F7_FCVT_S_W:
        w_fmt_result = {32'hFFFF_FFFF, bus.fpu_result[31:0]};
      c_F7_FCVT_W_S, c_F7_FCVT_W_D:
        w_fmt_result = {{32{bus.fpu_result[31]}}, bus.fpu_result[31:0]};
      default:
        w_fmt_result = bus.fpu_result;
    endcase
  end

  // Next-state and datapath update: accept, count down, capture, hand off
  always_comb begin
    state_d   = state_q;
    func7_d   = func7_q;
    func3_d   = func3_q;
    rs2_d     = rs2_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_EXEC: begin
        if (cnt_q == '0) begin
          result_d  = w_fmt_result;
          flags_d   = bus.fpu_flags;
          illegal_d = 1'b0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (w_rsp_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // A new request overrides the IDLE fall-back of a completing handshake.
    // An illegal rounding mode never reaches the core, so its registers stay put.
    if (w_accept) begin
      tag_d = bus.req_tag;
      if (w_rm_bad) begin
        result_d  = '0;
        flags_d   = '0;
        illegal_d = 1'b1;
        state_d   = ST_RESP;
      end else begin
        func7_d = bus.req_func7;
        func3_d = w_is_cmp ? bus.req_func3 : w_rm;
        rs2_d   = bus.req_rs2;
        op_a_d  = bus.req_op_a;
        op_b_d  = bus.req_op_b;
        cnt_d   = c_CNT_INIT;
        state_d = ST_EXEC;
      end
    end

    // Flags arriving on a handshake survive a simultaneous clear
    acc_d = (bus.fflags_clr ? 5'b0 : acc_q) | (w_rsp_hs ? flags_q : 5'b0);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      func7_q   <= '0;
      func3_q   <= '0;
      rs2_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      func7_q   <= func7_d;
      func3_q   <= func3_d;
      rs2_q     <= rs2_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
      acc_q     <= acc_d;
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.fpu_func7     = func7_q;
  assign bus.fpu_func3     = func3_q;
  assign bus.fpu_rs2       = rs2_q;
  assign bus.fpu_operand_a = op_a_q;
  assign bus.fpu_operand_b = op_b_q;
  assign bus.rsp_valid     = (state_q == ST_RESP);
  assign bus.rsp_result    = result_q;
  assign bus.rsp_flags     = flags_q;
  assign bus.rsp_tag       = tag_q;
  assign bus.rsp_illegal   = illegal_q;
  assign bus.fflags_acc    = acc_q;

endmodule

`default_nettype wire
